serial_frame_rx: RTL and testbench

// - Downstream consumer of the parallel-load shift register's serial output (its Q[0]).
// - Deframes a start/data/stop bit stream into DATA_W-bit words.
// - Presents each word on a one-entry valid/ready output buffer.
// - Flags framing errors and overruns; sits between the serialiser and any parallel sink.

---
 rtl/serial_frame_rx_if.sv | 24 ++
 rtl/serial_frame_rx.sv | 107 ++++++++++
 tb/tb_serial_frame_rx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Output stream of serial_frame_rx: a one-entry valid/ready word buffer.
//   data_out   : received word, held stable while data_valid=1
//   data_valid : buffer holds an unconsumed word
//   data_ready : sink accepts the word on an edge where data_valid=1
// The master modport belongs to the receiver and the slave modport to the sink.
interface serial_frame_rx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deframes a start(0) / DATA_W data bits (LSB first) / stop(1)
// serial stream into words. Each word is offered on a one-entry valid/ready
// buffer. Framing errors and overruns are reported on sticky flags.
//   clk       : clock; all state changes on posedge
//   rst_n     : asynchronous active-low reset
//   ser_in    : serial line, idle high
//   ser_en    : bit strobe; ser_in is sampled only on edges with ser_en=1
//   bus       : word output stream (data_out / data_valid / data_ready)
//   frame_err : sticky, set when a stop bit is sampled as 0
//   overrun   : sticky, set when a word completes while the buffer is still full
//   clr_err   : synchronous clear of both flags; a same-edge error event wins
module serial_frame_rx #(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ser_in,
  input  logic                ser_en,
  serial_frame_rx_if.master   bus,
  output logic                frame_err,
  output logic                overrun,
  input  logic                clr_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sreg;

  logic deliver;
  logic stop_bad;
  logic buf_free;
  logic ovr_evt;

  // Right shift with the new bit entering at the MSB, so after DATA_W bits
  // the first bit received lands in bit 0.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s,
                                                 input logic              b);
    logic [DATA_W-1:0] r;
    r = s >> 1;
    r[DATA_W-1] = b;
    return r;
  endfunction

  always_comb begin
    deliver  = ser_en && (state == ST_STOP) && ser_in;
    stop_bad = ser_en && (state == ST_STOP) && !ser_in;
    // A word being consumed on this very edge frees the slot for the new one.
    buf_free = !bus.data_valid || bus.data_ready;
    ovr_evt  = deliver && !buf_free;
  end

  // Deframing FSM: advances only on strobed edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (ser_en) begin
      case (state)
        ST_IDLE: begin
          if (!ser_in) begin
            state <= ST_DATA;
            cnt   <= '0;
          end
        end
        ST_DATA: begin
          sreg <= shift_in(sreg, ser_in);
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) state <= ST_STOP;
        end
        // A 0 in the stop slot is an error, not the start of a new frame.
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output buffer and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (deliver && buf_free) begin
        bus.data_out   <= sreg;
        bus.data_valid <= 1'b1;
      end else if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end

      if (stop_bad)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;

      if (ovr_evt)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam int DATA_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ser_in;
  logic ser_en;
  logic frame_err;
  logic overrun;
  logic clr_err;

  int checks = 0;
  int errors = 0;

  serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  serial_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_en    (ser_en),
    .bus       (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: collect strobed bits after a start bit, and once
  // DATA_W of them are in hand the next strobed bit is the stop bit.
  bit              m_busy = 1'b0;
  bit              m_q[$];
  logic [DATA_W-1:0] m_data = '0;
  logic            m_valid = 1'b0;
  logic            m_ferr = 1'b0;
  logic            m_ovr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_q     = {};
      m_data  = '0;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      bit got_word;
      bit ev_fe;
      bit ev_ovr;
      logic [DATA_W-1:0] w;
      got_word = 1'b0;
      ev_fe    = 1'b0;
      ev_ovr   = 1'b0;
      w        = '0;
      if (ser_en) begin
        if (!m_busy) begin
          if (ser_in == 1'b0) begin
            m_busy = 1'b1;
            m_q    = {};
          end
        end else if (m_q.size() < DATA_W) begin
          m_q.push_back(ser_in);
        end else begin
          if (ser_in) begin
            for (int i = 0; i < DATA_W; i++) w[i] = m_q[i];
            got_word = 1'b1;
          end else begin
            ev_fe = 1'b1;
          end
          m_busy = 1'b0;
        end
      end
      if (got_word) begin
        if (!m_valid || bus.data_ready) begin
          m_data  = w;
          m_valid = 1'b1;
        end else begin
          ev_ovr = 1'b1;
        end
      end else if (m_valid && bus.data_ready) begin
        m_valid = 1'b0;
      end
      if (ev_fe) m_ferr = 1'b1;
      else if (clr_err) m_ferr = 1'b0;
      if (ev_ovr) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
    end
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    check("cmp_valid", 32'(bus.data_valid), 32'(m_valid));
    check("cmp_data",  32'(bus.data_out),   32'(m_data));
    check("cmp_ferr",  32'(frame_err),      32'(m_ferr));
    check("cmp_ovr",   32'(overrun),        32'(m_ovr));
  end

  task automatic send_bit(input logic b, input int gap);
    ser_in = b;
    ser_en = 1'b1;
    @(negedge clk);
    ser_en = 1'b0;
    // Line wiggles while unstrobed; the receiver must ignore it.
    for (int i = 0; i < gap; i++) begin
      ser_in = ~b;
      @(negedge clk);
    end
    ser_in = 1'b1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input int gap,
                            input logic stopbit, input logic rdy_stop);
    logic rdy_save;
    send_bit(1'b0, gap);
    for (int i = 0; i < DATA_W; i++) send_bit(w[i], gap);
    rdy_save = bus.data_ready;
    bus.data_ready = rdy_stop;
    send_bit(stopbit, 0);
    bus.data_ready = rdy_save;
  endtask

  task automatic consume();
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  logic [DATA_W-1:0] b2b [3];

  initial begin
    rst_n = 1'b0;
    ser_in = 1'b1;
    ser_en = 1'b0;
    clr_err = 1'b0;
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(bus.data_valid), 32'h0);
    check("rst_data",  32'(bus.data_out),   32'h0);
    check("rst_ferr",  32'(frame_err),      32'h0);
    check("rst_ovr",   32'(overrun),        32'h0);

    // Basic frame 0xD: bits 0,1,0,1,1,1.
    send_frame(4'hD, 0, 1'b1, 1'b0);
    check("basic_valid", 32'(bus.data_valid), 32'h1);
    check("basic_data",  32'(bus.data_out),   32'hD);
    @(negedge clk);
    check("basic_hold",  32'(bus.data_valid), 32'h1);
    consume();
    check("basic_cons_valid", 32'(bus.data_valid), 32'h0);
    check("basic_cons_data",  32'(bus.data_out),   32'hD);

    // Asynchronous reset after the start bit and two data bits.
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data",  32'(bus.data_out),   32'h0);
    check("async_rst_valid", 32'(bus.data_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(4'hA, 0, 1'b1, 1'b0);
    check("after_rst_data",  32'(bus.data_out),   32'hA);
    check("after_rst_valid", 32'(bus.data_valid), 32'h1);
    consume();

    // Strobe every 3rd cycle.
    send_frame(4'h6, 2, 1'b1, 1'b0);
    check("strobe_data",  32'(bus.data_out),   32'h6);
    check("strobe_valid", 32'(bus.data_valid), 32'h1);
    consume();

    // Framing error; the bad stop bit must not start a frame.
    send_frame(4'h3, 0, 1'b0, 1'b0);
    check("ferr_set",   32'(frame_err),      32'h1);
    check("ferr_valid", 32'(bus.data_valid), 32'h0);
    for (int i = 0; i < DATA_W + 3; i++) send_bit(1'b1, 0);
    check("ferr_idle_valid", 32'(bus.data_valid), 32'h0);
    pulse_clr();
    check("ferr_clr", 32'(frame_err), 32'h0);

    // Overrun: second word arrives with the buffer full.
    send_frame(4'h1, 0, 1'b1, 1'b0);
    send_frame(4'h2, 0, 1'b1, 1'b0);
    check("ovr_set",   32'(overrun),        32'h1);
    check("ovr_data",  32'(bus.data_out),   32'h1);
    check("ovr_valid", 32'(bus.data_valid), 32'h1);
    consume();
    pulse_clr();
    check("ovr_clr", 32'(overrun), 32'h0);

    // Consume on the same edge as the new stop bit: no overrun.
    send_frame(4'h1, 0, 1'b1, 1'b0);
    send_frame(4'h2, 0, 1'b1, 1'b1);
    check("simul_ovr",   32'(overrun),        32'h0);
    check("simul_valid", 32'(bus.data_valid), 32'h1);
    check("simul_data",  32'(bus.data_out),   32'h2);
    consume();

    // Back-to-back frames with the sink always ready.
    b2b[0] = 4'hF;
    b2b[1] = 4'h0;
    b2b[2] = 4'h9;
    bus.data_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_frame(b2b[k], 0, 1'b1, 1'b1);
      check("b2b_valid", 32'(bus.data_valid), 32'h1);
      check("b2b_data",  32'(bus.data_out),   32'(b2b[k]));
    end
    @(negedge clk);
    check("b2b_drain", 32'(bus.data_valid), 32'h0);
    check("b2b_ferr",  32'(frame_err),      32'h0);
    check("b2b_ovr",   32'(overrun),        32'h0);
    bus.data_ready = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
